// File: rtl/hls_seq_pkg.sv
// Shared types for the HLS run sequencer: FSM states, response status codes
// and the memory-ownership decode used by the top level.
package hls_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GRANT     = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DRAIN     = 3'd4,
        S_RELEASE   = 3'd5,
        S_RESP      = 3'd6
    } seq_state_e;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK      = 2'b00;
    localparam status_t ST_TIMEOUT = 2'b01;
    localparam status_t ST_ABORT   = 2'b10;

    // The core owns the block memories from GRANT up to, but not including, RELEASE.
    function automatic logic owns_bram(seq_state_e s);
        return (s == S_GRANT) || (s == S_START) || (s == S_WAIT_DONE) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/hls_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
// Clear wins over enable so a reload and a count never collide.
module hls_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !(&count_q)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hls_run_sequencer.sv
// Launches an ap_ctrl_hs core for a programmed number of back-to-back runs,
// hands the block memories over for the run and reports status and counts.
module hls_run_sequencer
    import hls_seq_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int RUNS_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [RUNS_W-1:0] cmd_runs,
    input  logic [CNT_W-1:0]  cmd_timeout,
    input  logic              abort,
    output logic              ap_start,
    input  logic              ap_done,
    input  logic              ap_idle,
    input  logic              ap_ready,
    output logic              bram_owner,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [CNT_W-1:0]  rsp_cycles,
    output logic [RUNS_W-1:0] rsp_runs
);

    seq_state_e        state_q, state_d;
    logic [RUNS_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0]  timeout_q, timeout_d;
    status_t           status_q, status_d;
    logic [RUNS_W-1:0] runs_q, runs_d;
    logic              abort_q, abort_d;

    logic              ap_start_q, ap_start_d;
    logic              bram_owner_q, bram_owner_d;
    logic              busy_q, busy_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              timer_clr;
    logic              timer_en;
    logic              cyc_clr;
    logic              cyc_en;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  cycles;

    logic [RUNS_W-1:0] rem_after;
    logic              done_ev;
    logic              timed_out;
    logic              abort_rise;

    assign rem_after  = (remaining_q != '0) ? (remaining_q - RUNS_W'(1)) : '0;
    // The timer reads 0 in the first START cycle, so the limit is hit on the Nth cycle.
    assign timed_out  = (timeout_q != '0) && (timer == (timeout_q - CNT_W'(1)));
    assign abort_rise = abort && !abort_q;
    assign done_ev    = ((state_q == S_START) && ap_ready && ap_done) ||
                        ((state_q == S_WAIT_DONE) && ap_done);
    assign abort_d    = abort;

    assign timer_en = (state_q == S_START) || (state_q == S_WAIT_DONE);
    assign cyc_en   = owns_bram(state_q);

    hls_sat_counter #(.W(CNT_W)) u_timer (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .count (timer)
    );

    hls_sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (cyc_clr),
        .en    (cyc_en),
        .count (cycles)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timeout_d   = timeout_q;
        status_d    = status_q;
        runs_d      = runs_q;
        timer_clr   = 1'b0;
        cyc_clr     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    remaining_d = cmd_runs;
                    timeout_d   = cmd_timeout;
                    status_d    = ST_OK;
                    runs_d      = '0;
                    cyc_clr     = 1'b1;
                    state_d     = (cmd_runs == '0) ? S_RESP : S_GRANT;
                end
            end

            S_GRANT: begin
                timer_clr = 1'b1;
                state_d   = S_START;
            end

            S_START, S_WAIT_DONE: begin
                // Completion outranks abort, which outranks timeout.
                if (done_ev) begin
                    runs_d      = runs_q + RUNS_W'(1);
                    remaining_d = rem_after;
                    if (rem_after == '0) begin
                        state_d = S_RELEASE;
                    end else if (abort) begin
                        status_d = ST_ABORT;
                        state_d  = S_RELEASE;
                    end else begin
                        timer_clr = 1'b1;
                        state_d   = S_START;
                    end
                end else if (abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DRAIN;
                end else if (timed_out) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DRAIN;
                end else if ((state_q == S_START) && ap_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end

            S_DRAIN: begin
                if (ap_done) begin
                    runs_d = runs_q + RUNS_W'(1);
                end
                // A fresh abort edge lets the host reclaim memories from a hung core.
                if (ap_idle || ap_done || abort_rise) begin
                    state_d = S_RELEASE;
                end
            end

            S_RELEASE: begin
                state_d = S_RESP;
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ap_start_d   = (state_d == S_START);
        bram_owner_d = owns_bram(state_d);
        busy_d       = (state_d != S_IDLE);
        cmd_ready_d  = (state_d == S_IDLE);
        rsp_valid_d  = (state_d == S_RESP);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            timeout_q    <= '0;
            status_q     <= ST_OK;
            runs_q       <= '0;
            abort_q      <= 1'b0;
            ap_start_q   <= 1'b0;
            bram_owner_q <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            timeout_q    <= timeout_d;
            status_q     <= status_d;
            runs_q       <= runs_d;
            abort_q      <= abort_d;
            ap_start_q   <= ap_start_d;
            bram_owner_q <= bram_owner_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign ap_start   = ap_start_q;
    assign bram_owner = bram_owner_q;
    assign busy       = busy_q;
    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = status_q;
    assign rsp_cycles = cycles;
    assign rsp_runs   = runs_q;

endmodule
